// File: rtl/crballoon_dl_router.sv
// crballoon_dl_router: routes the HPS ioctl download into CRAZYBALLOON
// ROM write strobes and DIP bytes, and sequences the core reset.
module crballoon_dl_router #(
  parameter int PROG_SIZE = 12288,
  parameter int GFX_SIZE  = 2048,
  parameter int RST_HOLD  = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic        prog_we,
  output logic        gfx_we,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  dipsw0,
  output logic [7:0]  dipsw1,
  output logic        core_reset,
  output logic        rom_ok,
  output logic [15:0] byte_count
);

  localparam int CW = $clog2(RST_HOLD) + 1;
  localparam logic [24:0] PROG_END = 25'(PROG_SIZE);
  localparam logic [24:0] ROM_END = 25'(PROG_SIZE + GFX_SIZE);
  localparam logic [15:0] ROM_BYTES = 16'(PROG_SIZE + GFX_SIZE);
  localparam logic [CW-1:0] HOLD_INIT = CW'(RST_HOLD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t        state;
  logic          dl_q;
  logic [CW-1:0] hold_cnt;

  logic rom_wr;
  logic dip_wr;
  logic dl_rise;
  logic dl_fall;
  logic in_prog;
  logic in_gfx;

  // Decode the incoming strobe and download edges.
  always_comb begin
    rom_wr  = ioctl_wr && (ioctl_index == 8'd0);
    dip_wr  = ioctl_wr && (ioctl_index == 8'd254)
              && (ioctl_addr[24:1] == 24'd0);
    dl_rise = ioctl_download && !dl_q
              && (ioctl_index == 8'd0);
    dl_fall = !ioctl_download && dl_q;
    in_prog = ioctl_addr < PROG_END;
    in_gfx  = !in_prog && (ioctl_addr < ROM_END);
  end

  // Edge tracker resets high so a download cut by RESET is not re-armed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) dl_q <= 1'b1;
    else       dl_q <= ioctl_download;
  end

  // DIP bytes are captured in any state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dipsw0 <= 8'hFF;
      dipsw1 <= 8'hFF;
    end else if (dip_wr) begin
      if (ioctl_addr[0]) dipsw1 <= ioctl_dout;
      else               dipsw0 <= ioctl_dout;
    end
  end

  // Load/hold/run sequencer with registered strobes and core reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      rom_ok     <= 1'b0;
      prog_we    <= 1'b0;
      gfx_we     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      byte_count <= '0;
    end else begin
      prog_we <= 1'b0;
      gfx_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dl_rise) begin
            state      <= LOAD;
            byte_count <= '0;
            rom_ok     <= 1'b0;
          end
        end
        LOAD: begin
          if (rom_wr && (in_prog || in_gfx)) begin
            prog_we <= in_prog;
            gfx_we  <= in_gfx;
            wr_addr <= in_prog ? ioctl_addr[15:0]
                               : 16'(ioctl_addr - PROG_END);
            wr_data <= ioctl_dout;
            if (byte_count != 16'hFFFF)
              byte_count <= byte_count + 16'd1;
          end
          if (dl_fall) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (ext_reset) begin
            hold_cnt <= HOLD_INIT;
          end else if (hold_cnt == '0) begin
            rom_ok <= (byte_count == ROM_BYTES);
            if (byte_count == ROM_BYTES) begin
              state      <= RUN;
              core_reset <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RUN: begin
          if (ext_reset) begin
            state      <= HOLD;
            hold_cnt   <= HOLD_INIT;
            core_reset <= 1'b1;
          end else if (dl_rise) begin
            state      <= LOAD;
            byte_count <= '0;
            rom_ok     <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crballoon_dl_router.sv
// tb_crballoon_dl_router: scoreboard bench for the download router,
// covering full/short/oversize images, DIP capture, ext and async reset.
module tb_crballoon_dl_router;

  localparam int PROG = 12288;
  localparam int TOTAL = 14336;
  localparam int HOLD_N = 16;

  typedef struct packed {
    logic        gfx;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ext_reset = 1'b0;
  logic        prog_we;
  logic        gfx_we;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  dipsw0;
  logic [7:0]  dipsw1;
  logic        core_reset;
  logic        rom_ok;
  logic [15:0] byte_count;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   prog_cnt = 0;
  int   gfx_cnt = 0;

  crballoon_dl_router dut (
    .CLK(clk),
    .RESET(rst),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ext_reset(ext_reset),
    .prog_we(prog_we),
    .gfx_we(gfx_we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .dipsw0(dipsw0),
    .dipsw1(dipsw1),
    .core_reset(core_reset),
    .rom_ok(rom_ok),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (prog_we || gfx_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected strobe", {30'd0, prog_we, gfx_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe kind", {30'd0, prog_we, gfx_we},
              e.gfx ? 32'd1 : 32'd2);
        check("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      end
      prog_cnt += int'(prog_we);
      gfx_cnt  += int'(gfx_we);
    end
  end

  function automatic logic [7:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return v[7:0] ^ v[15:8] ^ 8'h3C;
  endfunction

  // Stream n bytes; the last byte coincides with the download fall.
  task automatic stream(input int n);
    exp_t x;
    prog_cnt = 0;
    gfx_cnt  = 0;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = pat(i);
      if (i == n - 1) ioctl_download = 1'b0;
      if (i < TOTAL) begin
        x.gfx  = (i >= PROG);
        x.addr = (i >= PROG) ? 16'(i - PROG) : 16'(i);
        x.data = pat(i);
        exp_q.push_back(x);
      end
      @(posedge clk); #1;
    end
    ioctl_wr = 1'b0;
  endtask

  // Core reset must hold for RST_HOLD cycles after the fall edge.
  task automatic after_load(input string tag, input logic ok);
    for (int k = 1; k < HOLD_N; k++) begin
      check({tag, " hold"}, {31'd0, core_reset}, 32'd1);
      @(posedge clk); #1;
    end
    check({tag, " pre-release"}, {31'd0, core_reset}, 32'd1);
    @(posedge clk); #1;
    check({tag, " rom_ok"}, {31'd0, rom_ok}, {31'd0, ok});
    check({tag, " core_reset"}, {31'd0, core_reset}, {31'd0, !ok});
    check({tag, " queue drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #20;
    check("rst core_reset", {31'd0, core_reset}, 32'd1);
    check("rst rom_ok", {31'd0, rom_ok}, 32'd0);
    check("rst strobes", {30'd0, prog_we, gfx_we}, 32'd0);
    check("rst wr_addr", {16'd0, wr_addr}, 32'd0);
    check("rst wr_data", {24'd0, wr_data}, 32'd0);
    check("rst byte_count", {16'd0, byte_count}, 32'd0);
    check("rst dipsw", {16'd0, dipsw1, dipsw0}, 32'hFFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Full image.
    stream(TOTAL);
    check("full byte_count", {16'd0, byte_count}, TOTAL);
    check("full rom_ok during hold", {31'd0, rom_ok}, 32'd0);
    after_load("full", 1'b1);
    check("full prog pulses", prog_cnt, PROG);
    check("full gfx pulses", gfx_cnt, TOTAL - PROG);

    // DIP bytes in RUN, including an out-of-range DIP address.
    ioctl_index = 8'd254;
    ioctl_wr    = 1'b1;
    ioctl_addr  = 25'd0;
    ioctl_dout  = 8'h5A;
    @(posedge clk); #1;
    ioctl_addr = 25'd1;
    ioctl_dout = 8'hC3;
    @(posedge clk); #1;
    ioctl_addr = 25'd2;
    ioctl_dout = 8'h00;
    @(posedge clk); #1;
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    @(posedge clk); #1;
    check("dipsw0", {24'd0, dipsw0}, 32'h5A);
    check("dipsw1", {24'd0, dipsw1}, 32'hC3);
    check("dip core_reset", {31'd0, core_reset}, 32'd0);
    check("dip byte_count", {16'd0, byte_count}, TOTAL);

    // ext_reset for 3 cycles in RUN.
    ext_reset = 1'b1;
    @(posedge clk); #1;
    check("ext asserts reset", {31'd0, core_reset}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ext_reset = 1'b0;
    for (int k = 1; k < HOLD_N; k++) begin
      @(posedge clk); #1;
      check("ext hold", {31'd0, core_reset}, 32'd1);
    end
    @(posedge clk); #1;
    check("ext release", {31'd0, core_reset}, 32'd0);
    check("ext rom_ok", {31'd0, rom_ok}, 32'd1);

    // Short image from RUN.
    stream(10000);
    check("short byte_count", {16'd0, byte_count}, 32'd10000);
    after_load("short", 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("short stays reset", {31'd0, core_reset}, 32'd1);
    check("short prog pulses", prog_cnt, 32'd10000);

    // Oversize image; tail bytes dropped.
    stream(14400);
    check("over byte_count", {16'd0, byte_count}, TOTAL);
    after_load("over", 1'b1);
    check("over prog pulses", prog_cnt, PROG);
    check("over gfx pulses", gfx_cnt, TOTAL - PROG);

    // Async RESET in the middle of a download.
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5000; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = pat(i);
      e.gfx  = 1'b0;
      e.addr = 16'(i);
      e.data = pat(i);
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    ioctl_wr = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid rst core_reset", {31'd0, core_reset}, 32'd1);
    check("mid rst rom_ok", {31'd0, rom_ok}, 32'd0);
    check("mid rst byte_count", {16'd0, byte_count}, 32'd0);
    check("mid rst wr_addr", {16'd0, wr_addr}, 32'd0);
    check("mid rst wr_data", {24'd0, wr_data}, 32'd0);
    check("mid rst dipsw", {16'd0, dipsw1, dipsw0}, 32'hFFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 5000; i < 6000; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = pat(i);
      @(posedge clk); #1;
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("cut core_reset", {31'd0, core_reset}, 32'd1);
    check("cut byte_count", {16'd0, byte_count}, 32'd0);
    check("cut rom_ok", {31'd0, rom_ok}, 32'd0);
    check("cut queue", exp_q.size(), 32'd0);

    // Fresh full image after the cut download.
    stream(TOTAL);
    after_load("fresh", 1'b1);
    check("fresh byte_count", {16'd0, byte_count}, TOTAL);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
